matrix_uart_printer: RTL and testbench

- Transmit-side counterpart of the matrix input path: reads one stored matrix from matrix memory and prints it over UART as ASCII decimal text.
- Storage format: word base+0 = m, base+1 = n, base+2 onward = m*n elements in row-major order.
- Started by the top FSM with a base address; contains its own 8N1 UART transmitter.

---
 rtl/mtx_pkg.sv | 37 +++
 rtl/matrix_uart_printer_if.sv | 22 ++
 rtl/uart_tx.sv | 56 +++++
 rtl/matrix_uart_printer.sv | 224 ++++++++++++++++++++++
 tb/tb_matrix_uart_printer.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/mtx_pkg.sv
// Shared constants for the matrix UART printer: ASCII codes, FSM encoding,
// dimension default and the powers-of-ten table used by the digit converter.
package mtx_pkg;

  localparam int DEF_MAX_DIM = 5;

  localparam logic [7:0] ASC_0     = 8'd48;
  localparam logic [7:0] ASC_SPACE = 8'd32;
  localparam logic [7:0] ASC_CR    = 8'd13;
  localparam logic [7:0] ASC_LF    = 8'd10;

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_RD_M     = 4'd1;
  localparam logic [3:0] S_RD_N     = 4'd2;
  localparam logic [3:0] S_CHECK    = 4'd3;
  localparam logic [3:0] S_RD_ELEM  = 4'd4;
  localparam logic [3:0] S_ELEM_CAP = 4'd5;
  localparam logic [3:0] S_CONVERT  = 4'd6;
  localparam logic [3:0] S_SEND     = 4'd7;
  localparam logic [3:0] S_SEP      = 4'd8;
  localparam logic [3:0] S_EOL      = 4'd9;
  localparam logic [3:0] S_DONE     = 4'd10;
  localparam logic [3:0] S_HDR_SP   = 4'd11;
  localparam logic [3:0] S_HDR_N    = 4'd12;

  // Digit weights, most significant first; sel 4 is the units digit.
  function automatic logic [15:0] pow10(input logic [2:0] sel);
    case (sel)
      3'd0:    return 16'd10000;
      3'd1:    return 16'd1000;
      3'd2:    return 16'd100;
      3'd3:    return 16'd10;
      default: return 16'd1;
    endcase
  endfunction

endpackage

// File: rtl/matrix_uart_printer_if.sv
// Control and matrix-memory read bus of the printer. The printer is the slave
// of the control side and owns the read strobe/address toward memory.
interface matrix_uart_printer_if;
  logic        start;
  logic [7:0]  base_addr;
  logic        busy;
  logic        done;
  logic        error;
  logic        rd_en;
  logic [7:0]  rd_addr;
  logic [31:0] rd_data;

  modport slave (
    input  start, base_addr, rd_data,
    output busy, done, error, rd_en, rd_addr
  );

  modport master (
    output start, base_addr, rd_data,
    input  busy, done, error, rd_en, rd_addr
  );
endinterface

// File: rtl/uart_tx.sv
// 8N1 UART transmitter, LSB first; one bit period is CLK_FREQ/BAUD_RATE clocks.
module uart_tx #(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx,
  output logic       tx_busy
);

  localparam int BIT_CLKS = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W    = (BIT_CLKS > 1) ? $clog2(BIT_CLKS + 1) : 1;

  logic [CNT_W-1:0] cnt_reg;
  logic [3:0]       bit_reg;
  logic [8:0]       shift_reg;
  logic             tx_reg;
  logic             busy_reg;

  // bit_reg 0 is the start bit, 1..8 data, 9 the stop bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg   <= '0;
      bit_reg   <= 4'd0;
      shift_reg <= '1;
      tx_reg    <= 1'b1;
      busy_reg  <= 1'b0;
    end else if (!busy_reg) begin
      if (tx_start) begin
        tx_reg    <= 1'b0;
        shift_reg <= {1'b1, tx_data};
        busy_reg  <= 1'b1;
        cnt_reg   <= '0;
        bit_reg   <= 4'd0;
      end
    end else if (cnt_reg == CNT_W'(BIT_CLKS - 1)) begin
      cnt_reg <= '0;
      if (bit_reg == 4'd9) begin
        busy_reg <= 1'b0;
      end else begin
        tx_reg    <= shift_reg[0];
        shift_reg <= {1'b1, shift_reg[8:1]};
        bit_reg   <= bit_reg + 4'd1;
      end
    end else begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  assign tx      = tx_reg;
  assign tx_busy = busy_reg;

endmodule

// File: rtl/matrix_uart_printer.sv
// Reads an m x n matrix from memory and prints it over UART as decimal text.
// Define MTX_PRINT_HEADER_EN to prefix the output with an "m n" header line.
module matrix_uart_printer
  import mtx_pkg::*;
#(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 115200,
  parameter int MAX_DIM   = DEF_MAX_DIM
) (
  input  logic                  clk,
  input  logic                  rst,
  matrix_uart_printer_if.slave  bus,
  output logic                  uart_tx
);

  localparam int DIM_W = $clog2(MAX_DIM + 1);

  logic [3:0]       state_reg, ret_reg, conv_next_reg;
  logic [7:0]       base_reg;
  logic [DIM_W-1:0] m_reg, n_reg, row_reg, col_reg;
  logic             m_ok_reg;
  logic [7:0]       idx_reg;
  logic [15:0]      value_reg;
  logic [2:0]       pow_sel_reg;
  logic [3:0]       digit_reg;
  logic             started_reg;
  logic [7:0]       byte_reg;
  logic             hdr_reg;
  logic             busy_reg, done_reg, error_reg;

  logic             rd_en;
  logic [7:0]       rd_addr;
  logic             tx_start;
  logic             tx_busy;
  logic [15:0]      cur_pow;

  function automatic logic dim_ok(input logic [31:0] w);
    return (w != 32'd0) && (w <= 32'(MAX_DIM));
  endfunction

  always_comb begin
    rd_en   = 1'b0;
    rd_addr = 8'd0;
    case (state_reg)
      S_RD_M: begin
        rd_en   = 1'b1;
        rd_addr = base_reg;
      end
      S_RD_N: begin
        rd_en   = 1'b1;
        rd_addr = base_reg + 8'd1;
      end
      S_RD_ELEM: begin
        rd_en   = 1'b1;
        rd_addr = base_reg + 8'd2 + idx_reg;
      end
      default: ;
    endcase
  end

  assign cur_pow  = pow10(pow_sel_reg);
  assign tx_start = (state_reg == S_SEND) && !tx_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      ret_reg       <= S_IDLE;
      conv_next_reg <= S_IDLE;
      base_reg      <= 8'd0;
      m_reg         <= '0;
      n_reg         <= '0;
      m_ok_reg      <= 1'b0;
      row_reg       <= '0;
      col_reg       <= '0;
      idx_reg       <= 8'd0;
      value_reg     <= 16'd0;
      pow_sel_reg   <= 3'd0;
      digit_reg     <= 4'd0;
      started_reg   <= 1'b0;
      byte_reg      <= 8'd0;
      hdr_reg       <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      error_reg     <= 1'b0;
    end else begin
      done_reg  <= 1'b0;
      error_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (bus.start) begin
            base_reg  <= bus.base_addr;
            busy_reg  <= 1'b1;
            row_reg   <= '0;
            col_reg   <= '0;
            idx_reg   <= 8'd0;
            hdr_reg   <= 1'b0;
            state_reg <= S_RD_M;
          end
        end
        S_RD_M: state_reg <= S_RD_N;
        S_RD_N: begin
          m_reg     <= bus.rd_data[DIM_W-1:0];
          m_ok_reg  <= dim_ok(bus.rd_data);
          state_reg <= S_CHECK;
        end
        S_CHECK: begin
          n_reg <= bus.rd_data[DIM_W-1:0];
          if (!(m_ok_reg && dim_ok(bus.rd_data))) begin
            error_reg <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= S_IDLE;
          end else begin
`ifdef MTX_PRINT_HEADER_EN
            hdr_reg       <= 1'b1;
            value_reg     <= 16'(m_reg);
            pow_sel_reg   <= 3'd0;
            digit_reg     <= 4'd0;
            started_reg   <= 1'b0;
            conv_next_reg <= S_HDR_SP;
            state_reg     <= S_CONVERT;
`else
            state_reg <= S_RD_ELEM;
`endif
          end
        end
        S_RD_ELEM: state_reg <= S_ELEM_CAP;
        S_ELEM_CAP: begin
          value_reg     <= bus.rd_data[15:0];
          pow_sel_reg   <= 3'd0;
          digit_reg     <= 4'd0;
          started_reg   <= 1'b0;
          conv_next_reg <= S_SEP;
          state_reg     <= S_CONVERT;
        end
        // One subtraction per cycle; a digit is complete once the remainder
        // drops below the current weight. Leading zeros are skipped except
        // for the units position so that 0 still prints.
        S_CONVERT: begin
          if (value_reg >= cur_pow) begin
            value_reg <= value_reg - cur_pow;
            digit_reg <= digit_reg + 4'd1;
          end else begin
            digit_reg   <= 4'd0;
            pow_sel_reg <= (pow_sel_reg == 3'd4) ? 3'd0 : pow_sel_reg + 3'd1;
            if (digit_reg != 4'd0 || started_reg || pow_sel_reg == 3'd4) begin
              started_reg <= 1'b1;
              byte_reg    <= ASC_0 + {4'd0, digit_reg};
              ret_reg     <= (pow_sel_reg == 3'd4) ? conv_next_reg : S_CONVERT;
              state_reg   <= S_SEND;
            end
          end
        end
        S_SEND: begin
          if (!tx_busy) state_reg <= ret_reg;
        end
        S_SEP: begin
          if (!hdr_reg && ((col_reg + DIM_W'(1)) < n_reg)) begin
            byte_reg <= ASC_SPACE;
            col_reg  <= col_reg + DIM_W'(1);
            idx_reg  <= idx_reg + 8'd1;
            ret_reg  <= S_RD_ELEM;
          end else begin
            byte_reg <= ASC_CR;
            ret_reg  <= S_EOL;
          end
          state_reg <= S_SEND;
        end
        S_EOL: begin
          byte_reg  <= ASC_LF;
          state_reg <= S_SEND;
          if (hdr_reg) begin
            hdr_reg <= 1'b0;
            ret_reg <= S_RD_ELEM;
          end else begin
            col_reg <= '0;
            idx_reg <= idx_reg + 8'd1;
            row_reg <= row_reg + DIM_W'(1);
            ret_reg <= ((row_reg + DIM_W'(1)) == m_reg) ? S_DONE : S_RD_ELEM;
          end
        end
        S_HDR_SP: begin
          byte_reg  <= ASC_SPACE;
          ret_reg   <= S_HDR_N;
          state_reg <= S_SEND;
        end
        S_HDR_N: begin
          value_reg     <= 16'(n_reg);
          pow_sel_reg   <= 3'd0;
          digit_reg     <= 4'd0;
          started_reg   <= 1'b0;
          conv_next_reg <= S_SEP;
          state_reg     <= S_CONVERT;
        end
        S_DONE: begin
          if (!tx_busy) begin
            done_reg  <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= S_IDLE;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  uart_tx #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE)
  ) u_tx (
    .clk      (clk),
    .rst      (rst),
    .tx_data  (byte_reg),
    .tx_start (tx_start),
    .tx       (uart_tx),
    .tx_busy  (tx_busy)
  );

  assign bus.rd_en   = rd_en;
  assign bus.rd_addr = rd_addr;
  assign bus.busy    = busy_reg;
  assign bus.done    = done_reg;
  assign bus.error   = error_reg;

endmodule

// File: tb/tb_matrix_uart_printer.sv
// Directed bench for matrix_uart_printer: decodes the serial line and compares
// the byte stream and handshake pulses against hand-written expectations.
module tb_matrix_uart_printer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic uart_tx;

  matrix_uart_printer_if bus ();

  matrix_uart_printer #(
    .CLK_FREQ  (16),
    .BAUD_RATE (1),
    .MAX_DIM   (5)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .uart_tx (uart_tx)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:255];
  always @(posedge clk) if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];

  int n_cmp = 0;
  int n_bad = 0;
  string crlf;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  // Serial decoder: 16 clocks per bit, samples mid-bit.
  logic [7:0] rx_q [$];
  int stop_err = 0;
  initial begin : rx_decode
    logic [7:0] b;
    forever begin
      @(posedge clk); #1;
      if (!rst && uart_tx === 1'b0) begin
        repeat (7) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (16) @(posedge clk); #1;
          b[i] = uart_tx;
        end
        repeat (16) @(posedge clk); #1;
        if (uart_tx !== 1'b1) stop_err++;
        rx_q.push_back(b);
      end
    end
  end

  function automatic string hdr(input int m, input int n);
`ifdef MTX_PRINT_HEADER_EN
    return $sformatf("%0d %0d%s", m, n, crlf);
`else
    return "";
`endif
  endfunction

  task automatic run_print(input string name, input logic [7:0] base, input string exp,
                           input bit exp_err, input bit second_start);
    int  q0, se0, done_n, err_n, low_n, k, end_k;
    bit  ended, prev_busy;
    q0  = rx_q.size();
    se0 = stop_err;
    @(negedge clk);
    bus.start = 1'b1;
    bus.base_addr = base;
    @(negedge clk);
    bus.start = 1'b0;
    bus.base_addr = 8'h00;
    check_value({name, ".busy_on"}, 32'(bus.busy), 32'd1);
    done_n = 0; err_n = 0; low_n = 0; k = 0; end_k = 0;
    ended = 1'b0; prev_busy = 1'b1;
    while (!ended && k < 20000) begin
      @(negedge clk);
      k++;
      if (second_start && k == 400) begin
        bus.start = 1'b1;
        bus.base_addr = 8'h40;
      end else if (second_start && k == 401) begin
        bus.start = 1'b0;
        bus.base_addr = 8'h00;
      end
      if (uart_tx === 1'b0) low_n++;
      if (bus.done === 1'b1 || bus.error === 1'b1) begin
        if (bus.done === 1'b1) done_n++;
        if (bus.error === 1'b1) err_n++;
        ended = 1'b1;
        end_k = k;
        check_value({name, ".busy_at_end"}, 32'(bus.busy), 32'd0);
        check_value({name, ".busy_before_end"}, 32'(prev_busy), 32'd1);
      end
      prev_busy = bus.busy;
    end
    check_value({name, ".finished_in_time"}, 32'(ended), 32'd1);
    repeat (40) begin
      @(negedge clk);
      if (bus.done === 1'b1) done_n++;
      if (bus.error === 1'b1) err_n++;
      if (uart_tx === 1'b0) low_n++;
    end
    check_value({name, ".done_pulses"}, 32'(done_n), exp_err ? 32'd0 : 32'd1);
    check_value({name, ".error_pulses"}, 32'(err_n), exp_err ? 32'd1 : 32'd0);
    if (exp_err) begin
      check_value({name, ".error_within_5"}, 32'(end_k <= 5), 32'd1);
      check_value({name, ".line_low_cycles"}, 32'(low_n), 32'd0);
    end
    check_value({name, ".byte_count"}, 32'(rx_q.size() - q0), 32'(exp.len()));
    for (int i = 0; i < exp.len(); i++) begin
      logic [7:0] got;
      got = (q0 + i < rx_q.size()) ? rx_q[q0 + i] : 8'h00;
      check_value($sformatf("%s.byte%0d", name, i), 32'(got), 32'(exp[i]));
    end
    check_value({name, ".stop_bits_bad"}, 32'(stop_err - se0), 32'd0);
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    crlf = $sformatf("%c%c", 8'd13, 8'd10);
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    mem[8'h10] = 2; mem[8'h11] = 3;
    mem[8'h12] = 1; mem[8'h13] = 2; mem[8'h14] = 3;
    mem[8'h15] = 4; mem[8'h16] = 5; mem[8'h17] = 6;
    mem[8'h20] = 1; mem[8'h21] = 3;
    mem[8'h22] = 0; mem[8'h23] = 32'h0001_038B; mem[8'h24] = 32'hABCD_FFFF;
    mem[8'h28] = 1; mem[8'h29] = 5;
    mem[8'h2A] = 10; mem[8'h2B] = 100; mem[8'h2C] = 1000; mem[8'h2D] = 10000; mem[8'h2E] = 5;
    mem[8'h30] = 6; mem[8'h31] = 3;
    mem[8'h38] = 2; mem[8'h39] = 0;
    mem[8'h40] = 1; mem[8'h41] = 1; mem[8'h42] = 9;
    mem[8'hFE] = 1; mem[8'hFF] = 1; mem[8'h00] = 7;

    bus.start = 1'b0;
    bus.base_addr = 8'h00;
    rst = 1'b1;
    repeat (4) @(negedge clk);
    check_value("reset.rd_en", 32'(bus.rd_en), 32'd0);
    check_value("reset.rd_addr", 32'(bus.rd_addr), 32'd0);
    check_value("reset.uart_tx", 32'(uart_tx), 32'd1);
    check_value("reset.busy", 32'(bus.busy), 32'd0);
    check_value("reset.done", 32'(bus.done), 32'd0);
    check_value("reset.error", 32'(bus.error), 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    run_print("m2x3", 8'h10, {hdr(2, 3), "1 2 3", crlf, "4 5 6", crlf}, 1'b0, 1'b0);
    run_print("digits", 8'h20, {hdr(1, 3), "0 907 65535", crlf}, 1'b0, 1'b0);
    run_print("n5", 8'h28, {hdr(1, 5), "10 100 1000 10000 5", crlf}, 1'b0, 1'b0);
    run_print("bad_m6", 8'h30, "", 1'b1, 1'b0);
    run_print("bad_n0", 8'h38, "", 1'b1, 1'b0);
    run_print("restart", 8'h10, {hdr(2, 3), "1 2 3", crlf, "4 5 6", crlf}, 1'b0, 1'b1);

    // Abort a frame while the first element byte ('1' = 0x31, bit 3 = 0) is on the line.
    begin : reset_mid_frame
      int  w;
      bit  seen;
      @(negedge clk);
      bus.start = 1'b1;
      bus.base_addr = 8'h10;
      @(negedge clk);
      bus.start = 1'b0;
      w = 0; seen = 1'b0;
      while (!seen && w < 2000) begin
        @(negedge clk);
        w++;
        if (uart_tx === 1'b0) seen = 1'b1;
      end
      check_value("rstmid.start_bit_seen", 32'(seen), 32'd1);
      repeat (70) @(negedge clk);
      check_value("rstmid.bit3_low", 32'(uart_tx), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      check_value("rstmid.uart_tx", 32'(uart_tx), 32'd1);
      check_value("rstmid.busy", 32'(bus.busy), 32'd0);
      rst = 1'b0;
      repeat (200) @(negedge clk);
    end
    run_print("after_rst", 8'h10, {hdr(2, 3), "1 2 3", crlf, "4 5 6", crlf}, 1'b0, 1'b0);
    run_print("wrap", 8'hFE, {hdr(1, 1), "7", crlf}, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
